// File: rtl/button_tick_array.sv
// Multi-channel button front end: per-channel 2-flop synchroniser, debounce,
// press-tick generation and optional typematic auto-repeat.
module button_tick_array #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [N_BTN-1:0] i_BTN,
  input  logic [N_BTN-1:0] i_REPEAT_EN,
  output logic [N_BTN-1:0] o_TICK,
  output logic [N_BTN-1:0] o_LEVEL,
  output logic             o_TICK_ANY
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_PEND,
    S_HELD,
    S_RELEASE_PEND
  } state_t;

  logic [N_BTN-1:0] tick_vec_d;
  logic             tick_any_d;
  logic             tick_any_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic [1:0]      sync_q, sync_d;
      logic            sync;
      logic            mismatch;
      logic            settle;
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;
      logic            level_q, level_d;
      logic            tick_q, tick_d;
      state_t          state_q, state_d;
      logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
      logic [RP_W-1:0] rp_target;
      logic            phase_q, phase_d;

      always_comb begin
        sync_d    = {sync_q[0], i_BTN[gi]};
        sync      = sync_q[1];
        mismatch  = (sync != level_q);
        settle    = mismatch && (db_cnt_q == DB_LAST);
        db_cnt_d  = '0;
        if (mismatch && !settle) begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
        level_d   = level_q ^ settle;
        state_d   = state_q;
        tick_d    = 1'b0;
        rp_cnt_d  = rp_cnt_q;
        phase_d   = phase_q;
        rp_target = phase_q ? RP_PERIOD : RP_DELAY;

        case (state_q)
          S_RELEASED, S_PRESS_PEND: begin
            if (settle) begin
              state_d  = S_HELD;
              tick_d   = 1'b1;
              rp_cnt_d = '0;
              phase_d  = 1'b0;
            end else begin
              state_d = sync ? S_PRESS_PEND : S_RELEASED;
            end
          end
          S_HELD, S_RELEASE_PEND: begin
            if (settle) begin
              state_d  = S_RELEASED;
              rp_cnt_d = '0;
              phase_d  = 1'b0;
            end else begin
              state_d = sync ? S_HELD : S_RELEASE_PEND;
              if (state_q == S_HELD && i_REPEAT_EN[gi]) begin
                // Hold one cycle at the threshold if a tick just fired, so
                // a period of 1 still leaves a low cycle between ticks.
                if (rp_cnt_q + RP_W'(1) == rp_target) begin
                  if (!tick_q) begin
                    tick_d   = 1'b1;
                    rp_cnt_d = '0;
                    phase_d  = 1'b1;
                  end
                end else begin
                  rp_cnt_d = rp_cnt_q + RP_W'(1);
                end
              end
            end
          end
          default: state_d = S_RELEASED;
        endcase
      end

      always_ff @(posedge i_CLK) begin
        if (i_RST) begin
          sync_q   <= '0;
          db_cnt_q <= '0;
          level_q  <= 1'b0;
          tick_q   <= 1'b0;
          state_q  <= S_RELEASED;
          rp_cnt_q <= '0;
          phase_q  <= 1'b0;
        end else begin
          sync_q   <= sync_d;
          db_cnt_q <= db_cnt_d;
          level_q  <= level_d;
          tick_q   <= tick_d;
          state_q  <= state_d;
          rp_cnt_q <= rp_cnt_d;
          phase_q  <= phase_d;
        end
      end

      assign tick_vec_d[gi] = tick_d;
      assign o_TICK[gi]     = tick_q;
      assign o_LEVEL[gi]    = level_q;
    end
  endgenerate

  always_comb begin
    tick_any_d = |tick_vec_d;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      tick_any_q <= 1'b0;
    end else begin
      tick_any_q <= tick_any_d;
    end
  end

  assign o_TICK_ANY = tick_any_q;

endmodule
